// File: rtl/trisc_core_param.sv
// TRISC accumulator core: parametrised width/depth, on-chip program/data RAM,
// program-load port, carry/zero flags, branches, output register and halt.
module trisc_core_param #(
  parameter int DW = 8,
  parameter int AW = 4,
  localparam int IW = 4 + DW
) (
  input  logic          SysClock,
  input  logic          Reset,
  input  logic          Mode,
  input  logic          LoadValid,
  input  logic [IW-1:0] LoadData,
  input  logic          LoadClear,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] LoadAddr,
  output logic [DW-1:0] ACC,
  output logic [DW-1:0] OutReg,
  output logic [3:0]    Opcode,
  output logic          Zero,
  output logic          Carry,
  output logic          Halted
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_D    = 3'd3,
    S_E    = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_CLR = 4'hC;
  localparam logic [3:0] OP_NOT = 4'hD;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] load_addr_q, load_addr_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] out_q, out_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;

  logic [IW-1:0] mem_q [2**AW];
  logic [IW-1:0] rd_data_q;
  logic [AW-1:0] rd_addr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [IW-1:0] mem_wdata;

  logic [3:0]    opcode;
  logic [DW-1:0] operand;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] mem_operand;
  logic [DW:0]   add_sum;
  logic [DW:0]   inc_sum;
  logic          upd_zero;
  logic          sta_we;

  assign opcode      = ir_q[IW-1:DW];
  assign operand     = ir_q[DW-1:0];
  assign op_addr     = operand[AW-1:0];
  assign mem_operand = rd_data_q[DW-1:0];
  assign add_sum     = {1'b0, acc_q} + {1'b0, mem_operand};
  assign inc_sum     = {1'b0, acc_q} + (DW+1)'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_addr_d = load_addr_q;
    acc_d       = acc_q;
    out_d       = out_q;
    ir_d        = ir_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    rd_addr     = pc_q;
    mem_we      = 1'b0;
    mem_waddr   = load_addr_q;
    mem_wdata   = LoadData;
    upd_zero    = 1'b0;
    sta_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!Mode) begin
          pc_d    = '0;
          acc_d   = '0;
          zero_d  = 1'b0;
          carry_d = 1'b0;
          state_d = S_F1;
        end
      end
      S_F1: begin
        rd_addr = pc_q;
        state_d = Mode ? S_IDLE : S_F2;
      end
      S_F2: begin
        if (Mode) begin
          state_d = S_IDLE;
        end else begin
          ir_d    = rd_data_q;
          pc_d    = pc_q + AW'(1);
          state_d = S_D;
        end
      end
      S_D: begin
        rd_addr = op_addr;
        state_d = Mode ? S_IDLE : S_E;
      end
      S_E: begin
        // An execute cycle always commits, even when Mode aborts the run.
        state_d = (opcode == OP_HLT) ? S_HALT : S_F1;
        if (Mode) state_d = S_IDLE;
        case (opcode)
          OP_LDA: begin acc_d = mem_operand; upd_zero = 1'b1; end
          OP_STA: sta_we = 1'b1;
          OP_ADD: begin {carry_d, acc_d} = add_sum; upd_zero = 1'b1; end
          OP_SUB: begin
            acc_d    = acc_q - mem_operand;
            carry_d  = (acc_q >= mem_operand);
            upd_zero = 1'b1;
          end
          OP_AND: begin acc_d = acc_q & mem_operand; upd_zero = 1'b1; end
          OP_OR:  begin acc_d = acc_q | mem_operand; upd_zero = 1'b1; end
          OP_LDI: begin acc_d = operand; upd_zero = 1'b1; end
          OP_JMP: pc_d = op_addr;
          OP_JZ:  if (zero_q) pc_d = op_addr;
          OP_JC:  if (carry_q) pc_d = op_addr;
          OP_INC: begin {carry_d, acc_d} = inc_sum; upd_zero = 1'b1; end
          OP_CLR: begin acc_d = '0; carry_d = 1'b0; upd_zero = 1'b1; end
          OP_NOT: begin acc_d = ~acc_q; upd_zero = 1'b1; end
          OP_OUT: out_d = acc_q;
          OP_NOP, OP_HLT: ;
          default: ;
        endcase
      end
      S_HALT: begin
        if (Mode) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (upd_zero) zero_d = (acc_d == '0);

    // STA owns the write port; a colliding load strobe is dropped without advancing.
    if (sta_we) begin
      mem_we    = 1'b1;
      mem_waddr = op_addr;
      mem_wdata = {4'h0, acc_q};
    end else if (Mode && !LoadClear && LoadValid) begin
      mem_we      = 1'b1;
      load_addr_d = load_addr_q + AW'(1);
    end
    if (Mode && LoadClear) load_addr_d = '0;
  end

  always_ff @(posedge SysClock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      load_addr_q <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      ir_q        <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      load_addr_q <= load_addr_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      ir_q        <= ir_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
    end
  end

  // RAM contents survive reset; read is registered with one-cycle latency.
  always_ff @(posedge SysClock) begin
    rd_data_q <= mem_q[rd_addr];
    if (mem_we && !Reset) mem_q[mem_waddr] <= mem_wdata;
  end

  assign PC       = pc_q;
  assign LoadAddr = load_addr_q;
  assign ACC      = acc_q;
  assign OutReg   = out_q;
  assign Opcode   = opcode;
  assign Zero     = zero_q;
  assign Carry    = carry_q;
  assign Halted   = (state_q == S_HALT);

endmodule
